// File: rtl/ascii_pkg.sv
// Shared types and default geometry for the ASCII tile scheduler and sampler.
// Holds the scheduler FSM state encoding and the default tile/glyph sizes.
package ascii_pkg;

    localparam int DEF_TILE_WIDTH   = 8;
    localparam int DEF_TILE_HEIGHT  = 8;
    localparam int DEF_ASCII_LEVELS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_SAMPLE,
        ST_WAIT_SMP,
        ST_EMIT
    } sched_state_t;

endpackage

// File: rtl/ascii_tile_scheduler.sv
// Walks a frame of tiles in raster order: reads each tile's glyph level,
// asks the external sampler for its bitmap, then streams it out row by row.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, busy, done   frame control (done pulses after the last row)
//   tile_rd_*           tile buffer read (data valid one cycle after en)
//   smp_*               sampler request / bitmap response
//   row_*               valid/ready row stream with tile column and pixel row
module ascii_tile_scheduler
    import ascii_pkg::*;
#(
    parameter int TILE_WIDTH   = DEF_TILE_WIDTH,
    parameter int TILE_HEIGHT  = DEF_TILE_HEIGHT,
    parameter int ASCII_LEVELS = DEF_ASCII_LEVELS,
    parameter int TILES_X      = 80,
    parameter int TILES_Y      = 60,
    parameter int LEVEL_W      = $clog2(ASCII_LEVELS),
    parameter int TADDR_W      = $clog2(TILES_X * TILES_Y),
    parameter int TX_W         = $clog2(TILES_X),
    parameter int PY_W         = $clog2(TILES_Y * TILE_HEIGHT)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              tile_rd_en,
    output logic [TADDR_W-1:0]                tile_rd_addr,
    input  logic [LEVEL_W-1:0]                tile_rd_level,
    input  logic                              tile_rd_edge,
    output logic                              smp_enable,
    output logic                              smp_edge,
    output logic [ASCII_LEVELS-1:0]           smp_ascii,
    input  logic [TILE_WIDTH*TILE_HEIGHT-1:0] smp_pixels,
    input  logic                              smp_valid,
    output logic                              row_valid,
    input  logic                              row_ready,
    output logic [TILE_WIDTH-1:0]             row_data,
    output logic [TX_W-1:0]                   row_tx,
    output logic [PY_W-1:0]                   row_py,
    output logic                              row_last
);

    localparam int TY_W = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
    localparam int R_W  = (TILE_HEIGHT > 1) ? $clog2(TILE_HEIGHT) : 1;

    localparam logic [TX_W-1:0] TX_LAST = TX_W'(TILES_X - 1);
    localparam logic [TY_W-1:0] TY_LAST = TY_W'(TILES_Y - 1);
    localparam logic [R_W-1:0]  R_LAST  = R_W'(TILE_HEIGHT - 1);

    sched_state_t                      state;
    logic [TX_W-1:0]                   tx_q;
    logic [TY_W-1:0]                   ty_q;
    logic [R_W-1:0]                    r_q;
    logic [LEVEL_W-1:0]                level_q;
    logic [TILE_WIDTH*TILE_HEIGHT-1:0] tile_q;

    logic last_tile;
    logic last_row;
    logic xfer;

    assign last_tile = (tx_q == TX_LAST) && (ty_q == TY_LAST);
    assign last_row  = (r_q == R_LAST);
    assign xfer      = row_valid && row_ready;

    // Outputs below are pure functions of registered state, so they stay
    // stable while a row is stalled by row_ready.
    assign tile_rd_addr = TADDR_W'(ty_q) * TADDR_W'(TILES_X)
                        + TADDR_W'(tx_q);
    assign smp_ascii    = ASCII_LEVELS'(level_q);
    assign row_data     = tile_q[int'(r_q) * TILE_WIDTH +: TILE_WIDTH];
    assign row_tx       = tx_q;
    assign row_py       = PY_W'(ty_q) * PY_W'(TILE_HEIGHT) + PY_W'(r_q);
    assign row_last     = row_valid && last_tile && last_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            tx_q       <= '0;
            ty_q       <= '0;
            r_q        <= '0;
            level_q    <= '0;
            tile_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tile_rd_en <= 1'b0;
            smp_enable <= 1'b0;
            smp_edge   <= 1'b0;
            row_valid  <= 1'b0;
        end else begin
            done       <= 1'b0;
            tile_rd_en <= 1'b0;
            smp_enable <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        tx_q       <= '0;
                        ty_q       <= '0;
                        r_q        <= '0;
                        busy       <= 1'b1;
                        tile_rd_en <= 1'b1;
                        state      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    level_q    <= tile_rd_level;
                    smp_edge   <= tile_rd_edge;
                    smp_enable <= 1'b1;
                    state      <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    state <= ST_WAIT_SMP;
                end
                ST_WAIT_SMP: begin
                    if (smp_valid) begin
                        tile_q    <= smp_pixels;
                        row_valid <= 1'b1;
                        state     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (xfer) begin
                        if (!last_row) begin
                            r_q <= r_q + R_W'(1);
                        end else begin
                            r_q       <= '0;
                            row_valid <= 1'b0;
                            if (last_tile) begin
                                // Park counters at zero so idle outputs
                                // read as tile 0, row 0.
                                tx_q  <= '0;
                                ty_q  <= '0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= ST_IDLE;
                            end else begin
                                if (tx_q == TX_LAST) begin
                                    tx_q <= '0;
                                    ty_q <= ty_q + TY_W'(1);
                                end else begin
                                    tx_q <= tx_q + TX_W'(1);
                                end
                                tile_rd_en <= 1'b1;
                                state      <= ST_FETCH;
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_tile_scheduler.sv
// Randomized bench for ascii_tile_scheduler on a 2x2-tile frame.
// Tile buffer and sampler are modelled here; rows are checked against a queue.
module tb_ascii_tile_scheduler;

    localparam int TW = 8;
    localparam int TH = 8;
    localparam int AL = 8;
    localparam int NX = 2;
    localparam int NY = 2;
    localparam int NT = NX * NY;

    typedef struct {
        logic [TW-1:0] d;
        int            tx;
        int            py;
        bit            last;
        int            r;
        int            t;
    } row_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          tile_rd_en;
    logic [1:0]    tile_rd_addr;
    logic [2:0]    tile_rd_level = '0;
    logic          tile_rd_edge = 1'b0;
    logic          smp_enable;
    logic          smp_edge;
    logic [AL-1:0] smp_ascii;
    logic [63:0]   smp_pixels = '0;
    logic          smp_valid = 1'b0;
    logic          row_valid;
    logic          row_ready = 1'b0;
    logic [TW-1:0] row_data;
    logic [0:0]    row_tx;
    logic [3:0]    row_py;
    logic          row_last;

    always #5 clk = ~clk;

    ascii_tile_scheduler #(
        .TILE_WIDTH  (TW),
        .TILE_HEIGHT (TH),
        .ASCII_LEVELS(AL),
        .TILES_X     (NX),
        .TILES_Y     (NY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .tile_rd_en   (tile_rd_en),
        .tile_rd_addr (tile_rd_addr),
        .tile_rd_level(tile_rd_level),
        .tile_rd_edge (tile_rd_edge),
        .smp_enable   (smp_enable),
        .smp_edge     (smp_edge),
        .smp_ascii    (smp_ascii),
        .smp_pixels   (smp_pixels),
        .smp_valid    (smp_valid),
        .row_valid    (row_valid),
        .row_ready    (row_ready),
        .row_data     (row_data),
        .row_tx       (row_tx),
        .row_py       (row_py),
        .row_last     (row_last)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    logic [2:0] level_mem [NT];
    bit         edge_mem  [NT];
    row_t q [$];
    int   fetch_cnt, smp_cnt, fire_cnt, pop_cnt, done_cnt;
    bit   in_frame = 0;
    bit   exp_done_nxt = 0;
    bit   held = 0;
    bit   pend = 0;
    int   wcnt = 0;
    int   smp_lat = 1;
    int   ready_mode = 0;
    bit   stray_en = 0;
    bit   start_noise = 0;
    int   stall_tile = -1;
    int   stall_left = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fire_sampler();
        logic [63:0] px;
        row_t rw;
        px = {$urandom, $urandom};
        smp_valid  = 1'b1;
        smp_pixels = px;
        for (int r = 0; r < TH; r++) begin
            rw.d    = px[r*TW +: TW];
            rw.tx   = fire_cnt % NX;
            rw.py   = (fire_cnt / NX) * TH + r;
            rw.last = (fire_cnt == NT - 1) && (r == TH - 1);
            rw.r    = r;
            rw.t    = fire_cnt;
            q.push_back(rw);
        end
        fire_cnt++;
        pend = 0;
    endtask

    task automatic cycle();
        row_t f;
        bit   rdy;
        @(negedge clk);
        chk("done", done, exp_done_nxt);
        if (done) done_cnt++;
        exp_done_nxt = 0;
        chk("busy", busy, in_frame);

        if (tile_rd_en) begin
            chk("rd_addr", tile_rd_addr, fetch_cnt);
            chk("rd_count", fetch_cnt < NT, 1);
            tile_rd_level = level_mem[tile_rd_addr];
            tile_rd_edge  = edge_mem[tile_rd_addr];
            fetch_cnt++;
        end

        smp_valid = 1'b0;
        if (pend) begin
            if (wcnt == 0) fire_sampler();
            else wcnt--;
        end else if (stray_en && row_valid && $urandom_range(3) == 0) begin
            smp_valid  = 1'b1;
            smp_pixels = {$urandom, $urandom};
        end
        if (smp_enable) begin
            if (smp_cnt < NT) begin
                chk("smp_ascii", smp_ascii, {5'b0, level_mem[smp_cnt]});
                chk("smp_edge", smp_edge, edge_mem[smp_cnt]);
            end else begin
                chk("smp_count", smp_cnt, NT - 1);
            end
            pend = 1;
            wcnt = smp_lat - 1;
            smp_cnt++;
        end

        row_ready = 1'b0;
        if (row_valid) begin
            if (q.size() == 0) begin
                chk("row_early", 1, 0);
            end else begin
                f = q[0];
                chk("row_data", row_data, f.d);
                chk("row_tx", row_tx, f.tx);
                chk("row_py", row_py, f.py);
                chk("row_last", row_last, f.last);
                rdy = 1;
                if (ready_mode == 1) rdy = ($urandom_range(1) == 1);
                if (ready_mode == 2) begin
                    if (f.r == 2 && stall_tile != f.t) begin
                        stall_tile = f.t;
                        stall_left = 5;
                    end
                    if (stall_left > 0) begin
                        rdy = 0;
                        stall_left--;
                    end
                end
                row_ready = rdy;
                if (rdy) begin
                    void'(q.pop_front());
                    pop_cnt++;
                    if (f.last) begin
                        in_frame = 0;
                        exp_done_nxt = 1;
                    end
                end
            end
        end else if (held) begin
            chk("row_hold", row_valid, 1);
        end
        held = row_valid && !row_ready;

        start = in_frame && start_noise && ($urandom_range(3) == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        smp_valid = 1'b0;
        row_ready = 1'b0;
        pend = 0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", tile_rd_en, 0);
        chk("rst_smp_en", smp_enable, 0);
        chk("rst_row_valid", row_valid, 0);
        chk("rst_row_last", row_last, 0);
        chk("rst_rd_addr", tile_rd_addr, 0);
        chk("rst_smp_ascii", smp_ascii, 0);
        chk("rst_smp_edge", smp_edge, 0);
        chk("rst_row_data", row_data, 0);
        chk("rst_row_tx", row_tx, 0);
        chk("rst_row_py", row_py, 0);
        rst = 1'b0;
        q.delete();
        in_frame = 0;
        exp_done_nxt = 0;
        held = 0;
    endtask

    task automatic run_frame(input int lat, input int rmode, input bit stray,
                             input bit noise, input bit abort,
                             input bit timing);
        int cyc;
        smp_lat = lat;
        ready_mode = rmode;
        stray_en = stray;
        start_noise = noise;
        fetch_cnt = 0;
        smp_cnt = 0;
        fire_cnt = 0;
        pop_cnt = 0;
        done_cnt = 0;
        stall_tile = -1;
        stall_left = 0;
        for (int i = 0; i < NT; i++) begin
            level_mem[i] = 3'($urandom_range(7));
            edge_mem[i]  = 1'($urandom_range(1));
        end
        if (timing) begin
            level_mem[0] = 3'd3;
            edge_mem[0]  = 1'b1;
        end
        cycle();
        start = 1'b1;
        in_frame = 1;
        cyc = 0;
        while (done_cnt == 0 && cyc < 2000) begin
            cycle();
            cyc++;
            if (abort && row_valid && fire_cnt == 2) break;
        end
        if (abort) begin
            do_reset();
            repeat (6) cycle();
            chk("abort_no_done", done_cnt, 0);
            chk("abort_no_fetch", fetch_cnt, 2);
        end else begin
            chk("frame_done", done_cnt > 0, 1);
            if (timing) chk("frame_cycles", cyc, 1 + NT * (4 + TH));
            repeat (4) cycle();
            chk("done_count", done_cnt, 1);
            chk("rows", pop_cnt, NT * TH);
            chk("rows_left", q.size(), 0);
            chk("fetches", fetch_cnt, NT);
            chk("samples", smp_cnt, NT);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        do_reset();
        run_frame(1, 0, 0, 0, 0, 1);
        run_frame(1, 2, 1, 0, 0, 0);
        run_frame(11, 1, 1, 0, 0, 0);
        run_frame(1, 1, 0, 0, 1, 0);
        run_frame(1, 0, 0, 0, 0, 0);
        run_frame(2, 1, 1, 1, 0, 0);
        run_frame(int'($urandom_range(3)) + 1, 1, 1, 1, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
